// File: rtl/vga_token_buffer_pkg.sv
// Shared symbol codes and FSM state encoding for the VGA token buffer.
package vga_token_pkg;

  localparam logic [3:0] CODE_MINUS = 4'hB;
  localparam logic [3:0] CODE_EQ    = 4'hE;
  localparam logic [3:0] CODE_CLR   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EQ,
    ST_SIGN,
    ST_DIV,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/vga_token_buffer_if.sv
// Symbol and answer input channels of the token buffer.
interface vga_token_buffer_if #(
  parameter int ANS_W = 32
);
  // valid/ready: a word transfers on the clk edge where valid and ready are both high;
  // the master holds valid and data steady until that edge.
  logic [3:0]       sym_data;
  logic             sym_valid;
  logic             sym_ready;
  logic [ANS_W-1:0] ans_data;
  logic             ans_valid;
  logic             ans_ready;

  modport master (
    output sym_data, sym_valid, ans_data, ans_valid,
    input  sym_ready, ans_ready
  );

  modport slave (
    input  sym_data, sym_valid, ans_data, ans_valid,
    output sym_ready, ans_ready
  );
endinterface

// File: rtl/vga_token_buffer_div10.sv
// Combinational divide-by-ten step used to peel decimal digits off the answer.
module div10 #(
  parameter int ANS_W = 32
) (
  input  logic [ANS_W-1:0] dividend,
  output logic [ANS_W-1:0] quotient,
  output logic [3:0]       remainder
);

  assign quotient  = dividend / ANS_W'(10);
  assign remainder = 4'(dividend - quotient * ANS_W'(10));

endmodule

// File: rtl/vga_token_buffer.sv
// Display token buffer: appends keyed symbols and renders signed answers as E, [B], decimal digits.
module vga_token_buffer
  import vga_token_pkg::*;
#(
  parameter int MAX_TOKENS = 200,
  parameter int ANS_W      = 32,
  parameter int DIGITS     = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  vga_token_buffer_if.slave               bus,
  output logic [4*MAX_TOKENS-1:0]         token_to_vga,
  output logic [$clog2(MAX_TOKENS+1)-1:0] token_count,
  output logic                            busy,
  output logic                            overflow,
  output state_t                          fsm_state
);

  localparam int CNT_W = $clog2(MAX_TOKENS + 1);
  localparam int SP_W  = $clog2(DIGITS + 1);

  state_t           state;
  logic [ANS_W-1:0] value;
  logic [3:0]       stack [DIGITS];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  top_idx;
  logic [ANS_W-1:0] quot;
  logic [3:0]       rem;
  logic             wr_en;
  logic [3:0]       wr_code;
  logic             full;

  div10 #(.ANS_W(ANS_W)) u_div10 (
    .dividend  (value),
    .quotient  (quot),
    .remainder (rem)
  );

  assign bus.sym_ready = (state == ST_IDLE);
  assign bus.ans_ready = (state == ST_IDLE) && !bus.sym_valid;
  assign fsm_state     = state;
  assign top_idx       = sp - SP_W'(1);
  assign full          = (token_count == CNT_W'(MAX_TOKENS));

  // One slot write per cycle at most; the FSM decides what, the buffer decides whether it fits.
  always_comb begin
    wr_en   = 1'b0;
    wr_code = '0;
    case (state)
      ST_IDLE: begin
        if (bus.sym_valid && (bus.sym_data != CODE_CLR)) begin
          wr_en   = 1'b1;
          wr_code = bus.sym_data;
        end
      end
      ST_EQ: begin
        wr_en   = 1'b1;
        wr_code = CODE_EQ;
      end
      ST_SIGN: begin
        wr_en   = 1'b1;
        wr_code = CODE_MINUS;
      end
      ST_EMIT: begin
        wr_en   = 1'b1;
        wr_code = stack[top_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      token_to_vga <= '0;
      token_count  <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      sp           <= '0;
      value        <= '0;
    end else begin
      if (wr_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          for (int k = 0; k < MAX_TOKENS; k++) begin
            if (CNT_W'(k) == token_count) token_to_vga[4*k +: 4] <= wr_code;
          end
          token_count <= token_count + CNT_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (bus.sym_valid) begin
            if (bus.sym_data == CODE_CLR) begin
              token_to_vga <= '0;
              token_count  <= '0;
              overflow     <= 1'b0;
            end
          end else if (bus.ans_valid) begin
            value <= bus.ans_data;
            busy  <= 1'b1;
            sp    <= '0;
            state <= ST_EQ;
          end
        end
        ST_EQ: begin
          state <= value[ANS_W-1] ? ST_SIGN : ST_DIV;
        end
        ST_SIGN: begin
          // Two's-complement negate; the most negative value maps onto its unsigned magnitude.
          value <= -value;
          state <= ST_DIV;
        end
        ST_DIV: begin
          stack[sp] <= rem;
          sp        <= sp + SP_W'(1);
          value     <= quot;
          if (quot == '0) state <= ST_EMIT;
        end
        ST_EMIT: begin
          sp <= top_idx;
          if (sp == SP_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_token_buffer.sv
// Bench for vga_token_buffer: per-cycle comparison against a schedule-based model plus directed cases.
module tb_vga_token_buffer;
  import vga_token_pkg::*;

  localparam int MAXT  = 200;
  localparam int ANS_W = 32;
  localparam int SMAXT = 4;

  bit clk;
  logic rst;

  vga_token_buffer_if #(.ANS_W(ANS_W)) bus ();
  vga_token_buffer_if #(.ANS_W(ANS_W)) sbus ();

  logic [4*MAXT-1:0]  tok;
  logic [7:0]         cnt;
  logic               busy, ovf;
  state_t             st;
  logic [4*SMAXT-1:0] s_tok;
  logic [2:0]         s_cnt;
  logic               s_busy, s_ovf;
  state_t             s_st;

  vga_token_buffer #(.MAX_TOKENS(MAXT), .ANS_W(ANS_W), .DIGITS(10)) dut (
    .clk(clk), .rst(rst), .bus(bus), .token_to_vga(tok), .token_count(cnt),
    .busy(busy), .overflow(ovf), .fsm_state(st)
  );

  vga_token_buffer #(.MAX_TOKENS(SMAXT), .ANS_W(ANS_W), .DIGITS(10)) dut_small (
    .clk(clk), .rst(rst), .bus(sbus), .token_to_vga(s_tok), .token_count(s_cnt),
    .busy(s_busy), .overflow(s_ovf), .fsm_state(s_st)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: slot contents plus a per-cycle action queue for an answer being rendered
  // (-1 = a cycle with no write, otherwise the code written in that cycle).
  logic [3:0] m_slot [MAXT];
  int         m_count;
  bit         m_ovf;
  int         exp_q[$];
  int         m_act;

  function automatic void m_write(input int code);
    if (m_count == MAXT) m_ovf = 1'b1;
    else begin
      m_slot[m_count] = 4'(code);
      m_count++;
    end
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < MAXT; k++) m_slot[k] = 4'h0;
    m_count = 0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void m_render(input logic [ANS_W-1:0] a);
    longint v;
    longint mag;
    string  s;
    v = longint'($signed(a));
    exp_q.push_back(14);
    if (v < 0) begin
      exp_q.push_back(11);
      mag = -v;
    end else mag = v;
    s = $sformatf("%0d", mag);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(-1);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]) - 48);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      m_act = exp_q.pop_front();
      if (m_act >= 0) m_write(m_act);
    end else if (bus.sym_valid) begin
      if (bus.sym_data == 4'hF) m_clear();
      else m_write(int'(bus.sym_data));
    end else if (bus.ans_valid) begin
      m_render(bus.ans_data);
    end
  end

  logic [4*MAXT-1:0] m_vec;
  int                bad_k;

  always @(negedge clk) begin
    chk("token_count", 64'(cnt), 64'(m_count));
    chk("busy", 64'(busy), 64'(exp_q.size() > 0));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("sym_ready", 64'(bus.sym_ready), 64'(exp_q.size() == 0));
    chk("ans_ready", 64'(bus.ans_ready), 64'((exp_q.size() == 0) && !bus.sym_valid));
    m_vec = '0;
    for (int k = 0; k < MAXT; k++) if (k < m_count) m_vec[4*k +: 4] = m_slot[k];
    n_cmp++;
    if (tok !== m_vec) begin
      n_fail++;
      bad_k = 0;
      for (int k = MAXT - 1; k >= 0; k--) if (tok[4*k +: 4] !== m_vec[4*k +: 4]) bad_k = k;
      $display("FAIL token_to_vga: slot %0d got %h expected %h", bad_k, tok[4*bad_k +: 4], m_vec[4*bad_k +: 4]);
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.sym_valid = 1'b0;
    bus.ans_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] c);
    bus.sym_data  = c;
    bus.sym_valid = 1'b1;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
  endtask

  task automatic send_ans(input logic [ANS_W-1:0] v, output int lat);
    bus.ans_data  = v;
    bus.ans_valid = 1'b1;
    @(posedge clk); #1;
    bus.ans_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_slots(input string name, input int e[$]);
    logic [4*MAXT-1:0] ev;
    ev = '0;
    foreach (e[i]) ev[4*i +: 4] = 4'(e[i]);
    chk({name, "_count"}, 64'(cnt), 64'(e.size()));
    n_cmp++;
    if (tok !== ev) begin
      n_fail++;
      $display("FAIL %s_slots: got %0h expected %0h", name, tok[63:0], ev[63:0]);
    end
  endtask

  function automatic logic [ANS_W-1:0] rand_ans();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return ANS_W'($urandom_range(0, 99));
      2:       return ANS_W'($urandom());
      3:       return 32'h8000_0000;
      default: return ANS_W'(-int'($urandom_range(1, 999)));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int  lat;
  bit  sx, ax;

  initial begin
    rst = 1'b1;
    bus.sym_valid = 1'b0;  bus.ans_valid = 1'b0;  bus.sym_data = '0;  bus.ans_data = '0;
    sbus.sym_valid = 1'b0; sbus.ans_valid = 1'b0; sbus.sym_data = '0; sbus.ans_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_count", 64'(cnt), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_overflow", 64'(ovf), 0);
    chk("reset_sym_ready", 64'(bus.sym_ready), 1);
    chk("reset_ans_ready", 64'(bus.ans_ready), 1);
    chk("reset_tokens_zero", 64'(tok == '0), 1);
    @(posedge clk); #1;

    // 1 A 2 = 3
    send_sym(4'h1); send_sym(4'hA); send_sym(4'h2);
    send_ans(32'd3, lat);
    chk_slots("add", '{1, 10, 2, 14, 3});
    chk("add_busy_cycles", 64'(lat), 3);

    do_reset();
    send_ans(32'h8000_0000, lat);
    chk_slots("min_int", '{14, 11, 2, 1, 4, 7, 4, 8, 3, 6, 4, 8});
    chk("min_int_latency", 64'(lat), 22);

    do_reset();
    send_ans(32'd0, lat);
    chk_slots("zero", '{14, 0});
    chk("zero_latency", 64'(lat), 3);

    // Simultaneous offer: symbol first, answer on the following edge.
    do_reset();
    bus.sym_data = 4'h5; bus.sym_valid = 1'b1;
    bus.ans_data = 32'd7; bus.ans_valid = 1'b1;
    @(negedge clk);
    chk("both_ans_ready_low", 64'(bus.ans_ready), 0);
    chk("both_sym_ready_high", 64'(bus.sym_ready), 1);
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    chk("both_sym_taken", 64'(cnt), 1);
    chk("both_not_busy_yet", 64'(busy), 0);
    @(posedge clk); #1;
    bus.ans_valid = 1'b0;
    chk("both_ans_taken", 64'(busy), 1);
    for (int i = 0; i < 50 && busy; i++) begin @(posedge clk); #1; end
    chk_slots("both", '{5, 14, 7});

    // Reset while dividing 12345.
    do_reset();
    bus.ans_data = 32'd12345; bus.ans_valid = 1'b1;
    @(posedge clk); #1;
    bus.ans_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_in_div", 64'(st), 64'(ST_DIV));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", 64'(st), 64'(ST_IDLE));
    chk("abort_count", 64'(cnt), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_sym_ready", 64'(bus.sym_ready), 1);
    chk("abort_ans_ready", 64'(bus.ans_ready), 1);

    // Four-slot build: answer partially dropped, then cleared.
    sbus.sym_valid = 1'b1;
    sbus.sym_data = 4'h1; @(posedge clk); #1;
    sbus.sym_data = 4'h2; @(posedge clk); #1;
    sbus.sym_data = 4'h3; @(posedge clk); #1;
    sbus.sym_valid = 1'b0;
    sbus.ans_data = 32'd45; sbus.ans_valid = 1'b1;
    @(posedge clk); #1;
    sbus.ans_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!s_busy) break;
      lat++;
    end
    @(posedge clk); #1;
    chk("small_latency", 64'(lat), 5);
    chk("small_tokens", 64'(s_tok), 64'h0000_0000_0000_E321);
    chk("small_count", 64'(s_cnt), 4);
    chk("small_overflow", 64'(s_ovf), 1);
    sbus.sym_data = 4'h7; sbus.sym_valid = 1'b1;
    @(posedge clk); #1;
    sbus.sym_valid = 1'b0;
    chk("small_full_sym_dropped", 64'(s_tok), 64'h0000_0000_0000_E321);
    sbus.sym_data = 4'hF; sbus.sym_valid = 1'b1;
    @(posedge clk); #1;
    sbus.sym_valid = 1'b0;
    chk("small_clr_count", 64'(s_cnt), 0);
    chk("small_clr_tokens", 64'(s_tok), 0);
    chk("small_clr_overflow", 64'(s_ovf), 0);

    // Fill the large buffer past capacity, then render an answer into a full buffer.
    do_reset();
    for (int i = 0; i < MAXT + 5; i++) send_sym(4'($urandom_range(0, 14)));
    chk("fill_count", 64'(cnt), 200);
    chk("fill_overflow", 64'(ovf), 1);
    send_ans(32'hFFFF_FFFB, lat);
    chk("full_answer_latency", 64'(lat), 4);
    send_sym(4'hF);
    chk("fill_clear_overflow", 64'(ovf), 0);

    // Randomized traffic with strict valid/ready holding.
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        if (!bus.sym_valid && $urandom_range(0, 2) == 0) begin
          bus.sym_valid = 1'b1;
          bus.sym_data  = ($urandom_range(0, 149) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        end
        if (!bus.ans_valid && $urandom_range(0, 11) == 0) begin
          bus.ans_valid = 1'b1;
          bus.ans_data  = rand_ans();
        end
        @(negedge clk);
        sx = bus.sym_valid && bus.sym_ready;
        ax = bus.ans_valid && bus.ans_ready;
        @(posedge clk); #1;
        if (sx) bus.sym_valid = 1'b0;
        if (ax) bus.ans_valid = 1'b0;
      end
    end

    bus.sym_valid = 1'b0;
    bus.ans_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_token_buffer.md
VGA_TOKEN_BUFFER -- requirements
Module: vga_token_buffer

Interface
REQ-001 The block SHALL have parameter MAX_TOKENS, default 200, giving the number of 4-bit display slots.
REQ-002 The block SHALL have parameter ANS_W, default 32, giving the two's-complement answer width.
REQ-003 The block SHALL have parameter DIGITS, default 10, giving the maximum decimal digits of |answer|; DIGITS SHALL be at least the digit count of 2^(ANS_W-1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 sym_data  in  4  symbol code (0-9 digit, A/C/D operators, B minus, E equals, F clear).
REQ-006 sym_valid  in  1 / sym_ready  out  1  symbol handshake; transfer on a clk edge with both high.
REQ-007 ans_data  in  ANS_W  signed answer.
REQ-008 ans_valid  in  1 / ans_ready  out  1  answer handshake; transfer on a clk edge with both high.
REQ-009 token_to_vga  out  4*MAX_TOKENS  slot k in bits [4k+3:4k]; slot 0 is the leftmost on screen.
REQ-010 token_count  out  clog2(MAX_TOKENS+1)  number of filled slots.
REQ-011 busy  out  1  high while an answer is being rendered.
REQ-012 overflow  out  1  sticky; high once a write was dropped for lack of space.

Function
REQ-013 The FSM SHALL have states IDLE, EQ, SIGN, DIV and EMIT.
REQ-014 sym_ready SHALL equal (state==IDLE).
REQ-015 ans_ready SHALL equal (state==IDLE && !sym_valid), so a symbol wins a simultaneous offer.
REQ-016 An accepted symbol other than F SHALL be written to slot token_count, and token_count SHALL increment on the same edge.
REQ-017 An accepted F SHALL zero token_to_vga, token_count and overflow on the same edge, and SHALL NOT be stored.
REQ-018 On answer acceptance the block SHALL latch ans_data, set busy, and go to EQ.
REQ-019 In EQ the block SHALL write E (one cycle), then go to SIGN if the latched value is negative, else to DIV.
REQ-020 In SIGN the block SHALL write B (one cycle) and replace the latched value by its magnitude as ANS_W-bit unsigned; -2^(ANS_W-1) is thereby valid.
REQ-021 In DIV the block SHALL, each cycle, divide the value by 10, push the remainder onto an internal DIGITS-deep digit stack, and keep the quotient.
REQ-022 DIV SHALL leave for EMIT after the cycle whose quotient is 0; zero SHALL produce exactly one digit, 0.
REQ-023 In EMIT the block SHALL pop one digit per cycle, most significant first, writing each to the next slot, and SHALL return to IDLE after the last digit.
REQ-024 busy SHALL fall on the edge that enters IDLE.
REQ-025 Answer latency SHALL be 1 + s + 2n cycles from the acceptance edge to the IDLE return, where s=1 if negative else 0 and n = number of digits; leading zeros are never written.
REQ-026 Any write (symbol, E, B or digit) with token_count==MAX_TOKENS SHALL be dropped and SHALL set overflow; the FSM sequence and timing SHALL be unchanged.
REQ-027 Slots at index >= token_count SHALL read 0.

Reset
REQ-028 While rst is high on a clk edge, the block SHALL set state=IDLE, token_to_vga=0, token_count=0, busy=0, overflow=0 and empty the digit stack, aborting any in-progress answer; partial writes already made SHALL be cleared.
REQ-029 sym_ready SHALL be 1 and ans_ready SHALL be !sym_valid in the first cycle after reset.

Structure
REQ-030 Package vga_token_pkg SHALL hold the symbol code constants (CODE_MINUS=4'hB, CODE_EQ=4'hE, CODE_CLR=4'hF) and the FSM state enum.
REQ-031 A combinational sub-module div10 (ANS_W-bit input, quotient and 4-bit remainder outputs) SHALL implement the per-cycle division.

Verification
REQ-032 Symbols 1, A, 2 (ADD), then answer 3: slots = 1,A,2,E,3; token_count=5; busy high for exactly 3 cycles.
REQ-033 Answer -2147483648 on an empty buffer: slots = E,B,2,1,4,7,4,8,3,6,4,8; token_count=12; latency 1+1+20=22 cycles.
REQ-034 Answer 0: slots = E,0; token_count=2; latency 3 cycles.
REQ-035 MAX_TOKENS=4 build, symbols 1,2,3 then answer 45: slots = 1,2,3,E; overflow=1; then symbol F -> token_count=0, all slots 0, overflow=0.
REQ-036 sym_valid and ans_valid high together in IDLE: the symbol is accepted first, and the answer is accepted on the next edge.
REQ-037 rst asserted during DIV of answer 12345: next cycle state=IDLE, token_count=0, busy=0, sym_ready=1.
